alu_32: RTL and testbench
=========================

Name: alu_32

Overview:
- Registered 32-bit integer ALU for the single-cycle/multicycle MIPS-style datapath.
- Computes AND, OR, ADD, SUB and signed set-less-than on two operands, selected by a 3-bit control code from the ALU decoder.
- Result and zero flag are captured in output registers; the zero flag feeds branch (beq) logic.

Parameters:
- WIDTH, 32, operand/result width in bits; all behaviour below is stated for WIDTH=32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- srca  input  WIDTH  operand A
- srcb  input  WIDTH  operand B
- alucontrol  input  3  operation select
- Y  output  WIDTH  registered result
- Z  output  1  registered zero flag, 1 when Y == 0

Behaviour:
- Interface rule (already decided): one clock, clk; reset is asynchronous and active-high.
- Reset: while reset=1, Y=0 and Z=1 immediately, independent of clk. Release takes effect from the next rising edge.
- Latency: 1 cycle. Inputs sampled at rising edge N; Y/Z valid after edge N and held until edge N+1. No handshake; a new operation is accepted every cycle.
- Operation decode (alucontrol):
  - 000 AND: Y = A & B
  - 001 OR: Y = A | B
  - 010 ADD: Y = A + B, modulo 2^32; carry-out discarded.
  - 011 reserved: Y = 0
  - 100 AND-NOT: Y = A & ~B
  - 101 OR-NOT: Y = A | ~B
  - 110 SUB: Y = A - B = A + ~B + 1, modulo 2^32; borrow discarded.
  - 111 SLT: Y = 32'h1 if signed(A) < signed(B), else 32'h0.
- SLT arithmetic:
  - Compute diff = A - B.
  - less = diff[31] XOR overflow, where overflow = (A[31] != B[31]) && (diff[31] != A[31]).
  - Result is correct across the full signed range, e.g. A=80000000, B=00000001 -> 1.
- Overflow handling: none flagged on ADD/SUB; wrap silently.
- Zero flag: Z is computed from the next-Y value and registered on the same edge as Y, so Z always matches the currently held Y.
- Operand/control changes between edges have no effect on outputs until the next rising edge.
- Reset asserted mid-stream: outputs clear immediately. The first post-reset result appears at the first edge with reset=0.
- Implementation structure: purely combinational datapath (shared adder for ADD/SUB/SLT using B-invert + carry-in = alucontrol[2]), result mux, then output register. No other state.

Test Plan:
- Reset: assert reset asynchronously between edges -> Y=00000000, Z=1 immediately. Deassert, apply ADD 1+1 -> Y=00000002, Z=0 one cycle later.
- ADD: 00000000+00000000 -> Y=0, Z=1. 00000000+FFFFFFFF -> FFFFFFFF. 00000001+FFFFFFFF -> 00000000, Z=1 (wrap). 000000FF+00000001 -> 00000100.
- SUB: 0-0 -> 0, Z=1. 00000000-FFFFFFFF -> 00000001. 1-1 -> 0, Z=1. 00000100-00000001 -> 000000FF.
- SLT (signed): (0,0) -> 0, Z=1. (0,1) -> 1. (0,FFFFFFFF) -> 0. (1,0) -> 0. (FFFFFFFF,0) -> 1. (80000000,7FFFFFFF) -> 1, overflow case.
- AND/OR: FFFFFFFF&FFFFFFFF -> FFFFFFFF. FFFFFFFF&12345678 -> 12345678. 12345678&87654321 -> 02244220. 0&FFFFFFFF -> 0, Z=1. 12345678|87654321 -> 97755779. 0|FFFFFFFF -> FFFFFFFF. 0|0 -> 0, Z=1.
- Latency/reserved: change inputs mid-cycle -> outputs unchanged until next edge. Code 011 -> Y=0, Z=1. Code 100 with A=FFFFFFFF, B=0000FFFF -> FFFF0000. Code 101 with A=0, B=FFFFFFFF -> 00000000, Z=1.

Source files
------------

// File: rtl/alu_32.sv
// Registered integer ALU: AND/OR/ADD/SUB/SLT plus inverted-B logic ops, with a
// zero flag for branch decisions. One shared adder serves ADD, SUB and SLT.
module alu_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] Y,
  output logic             Z
);

  // Signed less-than from the subtractor output; overflow flips the sign bit.
  function automatic logic slt_less(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] diff
  );
    logic ovf;
    ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    return diff[WIDTH-1] ^ ovf;
  endfunction

  logic        [WIDTH-1:0] b_sel_p0;
  logic signed [WIDTH-1:0] sum_p0;
  logic        [WIDTH-1:0] y_next_p0;
  logic                    less_p0;

  // Stage p0: combinational datapath, B inverted and carry-in set by alucontrol[2]
  always_comb begin
    b_sel_p0  = alucontrol[2] ? ~srcb : srcb;
    sum_p0    = srca + b_sel_p0 + {{(WIDTH-1){1'b0}}, alucontrol[2]};
    less_p0   = slt_less(srca, srcb, sum_p0);
    y_next_p0 = '0;
    unique case (alucontrol[1:0])
      2'b00: y_next_p0 = srca & b_sel_p0;
      2'b01: y_next_p0 = srca | b_sel_p0;
      2'b10: y_next_p0 = sum_p0;
      2'b11: y_next_p0 = alucontrol[2] ? {{(WIDTH-1){1'b0}}, less_p0} : '0;
      default: y_next_p0 = '0;
    endcase
  end

  // Stage p1: output register; Z is derived from the same next value as Y
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Y <= '0;
      Z <= 1'b1;
    end else begin
      Y <= y_next_p0;
      Z <= (y_next_p0 == '0);
    end
  end

endmodule

// File: tb/tb_alu_32.sv
// Directed bench for alu_32: literal expectations per vector plus a per-cycle
// comparison against a behavioural model of the ALU operations.
module tb_alu_32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic [2:0]  alucontrol = '0;
  logic [31:0] Y;
  logic        Z;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_y;
  logic        exp_z;

  alu_32 #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .srca(srca), .srcb(srcb),
    .alucontrol(alucontrol), .Y(Y), .Z(Z)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return 32'd0;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_y <= 32'd0;
      exp_z <= 1'b1;
    end else begin
      exp_y <= model(alucontrol, srca, srcb);
      exp_z <= (model(alucontrol, srca, srcb) == 32'd0);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, got, want);
    end
  endtask

  task automatic op(input string name, input logic [2:0] c, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] ey, input logic ez);
    @(negedge clk);
    reset = 1'b0;
    alucontrol = c;
    srca = a;
    srcb = b;
    @(posedge clk);
    #1;
    check({name, ".Y"}, Y, ey);
    check({name, ".Z"}, {31'd0, Z}, {31'd0, ez});
    check({name, ".model"}, exp_y, ey);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("reset.Y", Y, 32'd0);
    check("reset.Z", {31'd0, Z}, 32'd1);

    fork
      forever begin
        @(negedge clk);
        check("cycle.Y", Y, exp_y);
        check("cycle.Z", {31'd0, Z}, {31'd0, exp_z});
      end
    join_none

    op("add_1_1",     3'b010, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0);
    op("add_0_0",     3'b010, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1);
    op("add_0_ff",    3'b010, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op("add_wrap",    3'b010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    op("add_carry",   3'b010, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0);
    op("sub_0_0",     3'b110, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1);
    op("sub_0_ff",    3'b110, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    op("sub_1_1",     3'b110, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1);
    op("sub_100_1",   3'b110, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0);
    op("slt_0_0",     3'b111, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1);
    op("slt_0_1",     3'b111, 32'h00000000, 32'h00000001, 32'h00000001, 1'b0);
    op("slt_0_m1",    3'b111, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    op("slt_1_0",     3'b111, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1);
    op("slt_m1_0",    3'b111, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    op("slt_ovf",     3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    op("slt_min_1",   3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0);
    op("slt_max_min", 3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1);
    op("and_ff_ff",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op("and_ff_pat",  3'b000, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0);
    op("and_pats",    3'b000, 32'h12345678, 32'h87654321, 32'h02244220, 1'b0);
    op("and_0_ff",    3'b000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    op("or_pats",     3'b001, 32'h12345678, 32'h87654321, 32'h97755779, 1'b0);
    op("or_0_ff",     3'b001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op("or_0_0",      3'b001, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1);
    op("reserved",    3'b011, 32'hFFFFFFFF, 32'h12345678, 32'h00000000, 1'b1);
    op("andnot",      3'b100, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0);
    op("ornot",       3'b101, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    op("ornot_pat",   3'b101, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 1'b0);

    // Mid-cycle input change must not disturb the held result.
    op("hold_base",   3'b010, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0);
    #1;
    srca = 32'hAAAAAAAA;
    srcb = 32'h0000000F;
    alucontrol = 3'b000;
    #2;
    check("hold.Y", Y, 32'h00000008);
    check("hold.Z", {31'd0, Z}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_next.Y", Y, 32'h0000000A);

    // Asynchronous reset between edges, then recovery.
    op("pre_reset",   3'b001, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset.Y", Y, 32'd0);
    check("async_reset.Z", {31'd0, Z}, 32'd1);
    op("post_reset",  3'b010, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, limit reached");
    $fatal(1, "timeout");
  end

endmodule
